// File: rtl/digi_clock_pkg.sv
// Shared types and helpers for the BCD wall clock.
//   bcd_t        : one packed BCD digit
//   SEG_*        : active-high seven-segment patterns {a,b,c,d,e,f,g}, a = bit 6
//   seg7_encode  : BCD digit -> segment pattern (non-decimal codes show blank)
//   presc_width  : bit width of a prescaler counting 0..hz-1
package digi_clock_pkg;

    typedef logic [3:0] bcd_t;

    localparam logic [6:0] SEG_BLANK = 7'b000_0000;
    localparam logic [6:0] SEG_0     = 7'b111_1110;
    localparam logic [6:0] SEG_1     = 7'b011_0000;
    localparam logic [6:0] SEG_2     = 7'b110_1101;
    localparam logic [6:0] SEG_3     = 7'b111_1001;
    localparam logic [6:0] SEG_4     = 7'b011_0011;
    localparam logic [6:0] SEG_5     = 7'b101_1011;
    localparam logic [6:0] SEG_6     = 7'b101_1111;
    localparam logic [6:0] SEG_7     = 7'b111_0000;
    localparam logic [6:0] SEG_8     = 7'b111_1111;
    localparam logic [6:0] SEG_9     = 7'b111_1011;

    function automatic logic [6:0] seg7_encode(input bcd_t d);
        case (d)
            4'd0:    return SEG_0;
            4'd1:    return SEG_1;
            4'd2:    return SEG_2;
            4'd3:    return SEG_3;
            4'd4:    return SEG_4;
            4'd5:    return SEG_5;
            4'd6:    return SEG_6;
            4'd7:    return SEG_7;
            4'd8:    return SEG_8;
            4'd9:    return SEG_9;
            default: return SEG_BLANK;
        endcase
    endfunction

    function automatic int presc_width(input int hz);
        return (hz > 2) ? $clog2(hz) : 1;
    endfunction

endpackage

// File: rtl/bcd_mod_counter.sv
// Two-digit BCD counter running MIN..MAX with wrap-around in both directions.
//   clk, rst_n     : clock, synchronous active-low reset (loads RST_VAL)
//   clr            : load MIN (highest priority after reset)
//   inc, dec       : step up / down this cycle (inc wins if both are set)
//   tens, units    : current value as BCD digits
//   carry, borrow  : combinational, high when this cycle's step wraps MAX->MIN / MIN->MAX
//   wrap           : carry | borrow
module bcd_mod_counter
    import digi_clock_pkg::*;
#(
    parameter int MIN     = 0,
    parameter int MAX     = 59,
    parameter int RST_VAL = MIN
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic inc,
    input  logic dec,
    output bcd_t tens,
    output bcd_t units,
    output logic carry,
    output logic borrow,
    output logic wrap
);

    localparam bcd_t MIN_T = bcd_t'(MIN / 10);
    localparam bcd_t MIN_U = bcd_t'(MIN % 10);
    localparam bcd_t MAX_T = bcd_t'(MAX / 10);
    localparam bcd_t MAX_U = bcd_t'(MAX % 10);
    localparam bcd_t RST_T = bcd_t'(RST_VAL / 10);
    localparam bcd_t RST_U = bcd_t'(RST_VAL % 10);

    bcd_t tens_q, tens_d;
    bcd_t units_q, units_d;
    logic at_min, at_max;

    always_comb begin
        at_min  = (tens_q == MIN_T) && (units_q == MIN_U);
        at_max  = (tens_q == MAX_T) && (units_q == MAX_U);
        tens_d  = tens_q;
        units_d = units_q;
        carry   = 1'b0;
        borrow  = 1'b0;
        if (clr) begin
            tens_d  = MIN_T;
            units_d = MIN_U;
        end else if (inc) begin
            if (at_max) begin
                tens_d  = MIN_T;
                units_d = MIN_U;
                carry   = 1'b1;
            end else if (units_q == 4'd9) begin
                tens_d  = tens_q + 4'd1;
                units_d = 4'd0;
            end else begin
                units_d = units_q + 4'd1;
            end
        end else if (dec) begin
            if (at_min) begin
                tens_d  = MAX_T;
                units_d = MAX_U;
                borrow  = 1'b1;
            end else if (units_q == 4'd0) begin
                tens_d  = tens_q - 4'd1;
                units_d = 4'd9;
            end else begin
                units_d = units_q - 4'd1;
            end
        end
    end

    assign wrap  = carry | borrow;
    assign tens  = tens_q;
    assign units = units_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tens_q  <= RST_T;
            units_q <= RST_U;
        end else begin
            tens_q  <= tens_d;
            units_q <= units_d;
        end
    end

endmodule

// File: rtl/digi_clock_bcd.sv
// HH:MM:SS BCD timekeeper with button setting and registered seven-segment outputs.
//   clk_inbuilt : system clock, everything on its rising edge
//   reset       : synchronous, active-low
//   set[3:0]    : raw buttons: [3] set mode, [2] decrement, [1] hour step, [0] minute step
//   D_H1..D_S2  : segment outputs {a..g}, index 1 = tens digit, 2 = units digit
//   pm          : PM flag (12-hour build only, else 0)
//   tick_1hz    : one-cycle pulse, high on the edge the seconds advance
module digi_clock_bcd
    import digi_clock_pkg::*;
#(
    parameter int CLK_HZ         = 50_000_000,
    parameter bit MODE_12H       = 1'b0,
    parameter bit SHOW_SECONDS   = 1'b1,
    parameter bit SEG_ACTIVE_LOW = 1'b0
) (
    input  logic       clk_inbuilt,
    input  logic       reset,
    input  logic [3:0] set,
    output logic [6:0] D_H1,
    output logic [6:0] D_H2,
    output logic [6:0] D_M1,
    output logic [6:0] D_M2,
    output logic [6:0] D_S1,
    output logic [6:0] D_S2,
    output logic       pm,
    output logic       tick_1hz
);

    localparam int               CNT_W    = presc_width(CLK_HZ);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(CLK_HZ - 1);
    localparam int               HR_MIN   = MODE_12H ? 1 : 0;
    localparam int               HR_MAX   = MODE_12H ? 12 : 23;
    localparam int               HR_RST   = MODE_12H ? 12 : 0;
    localparam bcd_t             HR_RST_T = bcd_t'(HR_RST / 10);
    localparam bcd_t             HR_RST_U = bcd_t'(HR_RST % 10);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       sync1_q, sync1_d, sync2_q, sync2_d;
    logic [1:0]       step_prev_q, step_prev_d;
    logic             tick_q, tick_d;
    logic             pm_q, pm_d;
    logic [6:0]       h1_q, h1_d, h2_q, h2_d, m1_q, m1_d, m2_q, m2_d, s1_q, s1_d, s2_q, s2_d;

    logic       set_mode, dir_dec, min_step, hr_step;
    logic [1:0] step_edge;
    logic       sec_inc, min_inc, min_dec, hr_inc, hr_dec;
    bcd_t       sec_t, sec_u, min_t, min_u, hr_t, hr_u;
    logic       sec_carry, sec_borrow, sec_wrap;
    logic       min_carry, min_borrow, min_wrap;
    logic       hr_carry, hr_borrow, hr_wrap;
    bcd_t       dh_t, dh_u, dm_t, dm_u, ds_t, ds_u;

    function automatic logic [6:0] seg_pol(input logic [6:0] s);
        return SEG_ACTIVE_LOW ? ~s : s;
    endfunction

    always_comb begin
        sync1_d     = set;
        sync2_d     = sync1_q;
        step_prev_d = sync2_q[1:0];
        set_mode    = sync2_q[3];
        dir_dec     = sync2_q[2];
        step_edge   = sync2_q[1:0] & ~step_prev_q;
        min_step    = set_mode & step_edge[0];
        hr_step     = set_mode & step_edge[1];

        // Set mode parks the prescaler at 0, so the first tick after leaving
        // it lands a full second later.
        tick_d = !set_mode && (cnt_q == CNT_MAX);
        cnt_d  = (set_mode || cnt_q == CNT_MAX) ? '0 : cnt_q + CNT_W'(1);

        // Steps only ever move their own field; the carry chain is tick-driven.
        sec_inc = tick_d;
        min_inc = (tick_d & sec_carry) | (min_step & ~dir_dec);
        min_dec = min_step & dir_dec;
        hr_inc  = (tick_d & sec_carry & min_carry) | (hr_step & ~dir_dec);
        hr_dec  = hr_step & dir_dec;

        // AM/PM flips whenever the hour crosses between 11 and 12.
        pm_d = pm_q ^ (MODE_12H &&
                       ((hr_inc && hr_t == 4'd1 && hr_u == 4'd1) ||
                        (hr_dec && hr_t == 4'd1 && hr_u == 4'd2)));

        // Display lags the counters by one edge, except in reset where the
        // reset time is shown on the same edge.
        if (!reset) begin
            dh_t = HR_RST_T; dh_u = HR_RST_U;
            dm_t = 4'd0;     dm_u = 4'd0;
            ds_t = 4'd0;     ds_u = 4'd0;
        end else begin
            dh_t = hr_t;  dh_u = hr_u;
            dm_t = min_t; dm_u = min_u;
            ds_t = sec_t; ds_u = sec_u;
        end
        h1_d = seg_pol((MODE_12H && dh_t == 4'd0) ? SEG_BLANK : seg7_encode(dh_t));
        h2_d = seg_pol(seg7_encode(dh_u));
        m1_d = seg_pol(seg7_encode(dm_t));
        m2_d = seg_pol(seg7_encode(dm_u));
        s1_d = seg_pol(SHOW_SECONDS ? seg7_encode(ds_t) : SEG_BLANK);
        s2_d = seg_pol(SHOW_SECONDS ? seg7_encode(ds_u) : SEG_BLANK);
    end

    bcd_mod_counter #(.MIN(0), .MAX(59), .RST_VAL(0)) u_sec (
        .clk(clk_inbuilt), .rst_n(reset), .clr(set_mode), .inc(sec_inc), .dec(1'b0),
        .tens(sec_t), .units(sec_u), .carry(sec_carry), .borrow(sec_borrow), .wrap(sec_wrap)
    );

    bcd_mod_counter #(.MIN(0), .MAX(59), .RST_VAL(0)) u_min (
        .clk(clk_inbuilt), .rst_n(reset), .clr(1'b0), .inc(min_inc), .dec(min_dec),
        .tens(min_t), .units(min_u), .carry(min_carry), .borrow(min_borrow), .wrap(min_wrap)
    );

    bcd_mod_counter #(.MIN(HR_MIN), .MAX(HR_MAX), .RST_VAL(HR_RST)) u_hr (
        .clk(clk_inbuilt), .rst_n(reset), .clr(1'b0), .inc(hr_inc), .dec(hr_dec),
        .tens(hr_t), .units(hr_u), .carry(hr_carry), .borrow(hr_borrow), .wrap(hr_wrap)
    );

    // Status flags the clock has no use for.
    logic unused_flags;
    assign unused_flags = ^{sec_borrow, sec_wrap, min_borrow, min_wrap, hr_carry, hr_borrow, hr_wrap};

    always_ff @(posedge clk_inbuilt) begin
        if (!reset) begin
            cnt_q       <= '0;
            sync1_q     <= '0;
            sync2_q     <= '0;
            step_prev_q <= '0;
            tick_q      <= 1'b0;
            pm_q        <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            step_prev_q <= step_prev_d;
            tick_q      <= tick_d;
            pm_q        <= pm_d;
        end
        h1_q <= h1_d;
        h2_q <= h2_d;
        m1_q <= m1_d;
        m2_q <= m2_d;
        s1_q <= s1_d;
        s2_q <= s2_d;
    end

    assign D_H1     = h1_q;
    assign D_H2     = h2_q;
    assign D_M1     = m1_q;
    assign D_M2     = m2_q;
    assign D_S1     = s1_q;
    assign D_S2     = s2_q;
    assign pm       = pm_q & MODE_12H;
    assign tick_1hz = tick_q;

endmodule

// File: tb/tb_digi_clock_bcd.sv
// Bench for digi_clock_bcd: three builds (24h, 12h, 24h active-low without seconds)
// share one clock. Stimulus pushes expected display states into a queue and raises
// a sample strobe; the monitor pops and compares on the falling edge.
module tb_digi_clock_bcd;

    logic       clk = 1'b0;
    logic       rst_n [3];
    logic [3:0] set_v [3];
    logic [6:0] h1 [3], h2 [3], m1 [3], m2 [3], s1 [3], s2 [3];
    logic       pm_o [3], tick_o [3];

    always #5 clk = ~clk;

    digi_clock_bcd #(.CLK_HZ(10), .MODE_12H(1'b0), .SHOW_SECONDS(1'b1), .SEG_ACTIVE_LOW(1'b0)) dut24 (
        .clk_inbuilt(clk), .reset(rst_n[0]), .set(set_v[0]),
        .D_H1(h1[0]), .D_H2(h2[0]), .D_M1(m1[0]), .D_M2(m2[0]), .D_S1(s1[0]), .D_S2(s2[0]),
        .pm(pm_o[0]), .tick_1hz(tick_o[0]));

    digi_clock_bcd #(.CLK_HZ(10), .MODE_12H(1'b1), .SHOW_SECONDS(1'b1), .SEG_ACTIVE_LOW(1'b0)) dut12 (
        .clk_inbuilt(clk), .reset(rst_n[1]), .set(set_v[1]),
        .D_H1(h1[1]), .D_H2(h2[1]), .D_M1(m1[1]), .D_M2(m2[1]), .D_S1(s1[1]), .D_S2(s2[1]),
        .pm(pm_o[1]), .tick_1hz(tick_o[1]));

    digi_clock_bcd #(.CLK_HZ(10), .MODE_12H(1'b0), .SHOW_SECONDS(1'b0), .SEG_ACTIVE_LOW(1'b1)) dutal (
        .clk_inbuilt(clk), .reset(rst_n[2]), .set(set_v[2]),
        .D_H1(h1[2]), .D_H2(h2[2]), .D_M1(m1[2]), .D_M2(m2[2]), .D_S1(s1[2]), .D_S2(s2[2]),
        .pm(pm_o[2]), .tick_1hz(tick_o[2]));

    typedef struct {
        int         dut;
        string      name;
        bit         disp;
        logic [6:0] h1, h2, m1, m2, s1, s2;
        logic       pm;
        logic       tick;
    } exp_t;

    exp_t exp_q[$];
    exp_t cur;
    int   n_chk = 0;
    int   n_err = 0;
    logic smp = 1'b0;

    // Hand-written segment table; -1 means blank.
    function automatic logic [6:0] sg(input int d, input bit inv);
        logic [6:0] r;
        case (d)
            0: r = 7'b1111110;  1: r = 7'b0110000;  2: r = 7'b1101101;
            3: r = 7'b1111001;  4: r = 7'b0110011;  5: r = 7'b1011011;
            6: r = 7'b1011111;  7: r = 7'b1110000;  8: r = 7'b1111111;
            9: r = 7'b1111011;  default: r = 7'b0000000;
        endcase
        return inv ? ~r : r;
    endfunction

    task automatic push_exp(input int d, input string nm, input int hh1, input int hh2,
                            input int mm1, input int mm2, input int ss1, input int ss2,
                            input logic p, input logic t, input bit inv);
        exp_t e;
        e.dut = d; e.name = nm; e.disp = 1'b1;
        e.h1 = sg(hh1, inv); e.h2 = sg(hh2, inv);
        e.m1 = sg(mm1, inv); e.m2 = sg(mm2, inv);
        e.s1 = sg(ss1, inv); e.s2 = sg(ss2, inv);
        e.pm = p; e.tick = t;
        exp_q.push_back(e);
    endtask

    task automatic push_tick(input int d, input string nm, input logic t);
        exp_t e;
        e.dut = d; e.name = nm; e.disp = 1'b0;
        e.h1 = '0; e.h2 = '0; e.m1 = '0; e.m2 = '0; e.s1 = '0; e.s2 = '0;
        e.pm = 1'b0; e.tick = t;
        exp_q.push_back(e);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_sample();
        smp = 1'b1;
        @(negedge clk);
        #1 smp = 1'b0;
    endtask

    task automatic pulse(input int d, input logic [1:0] b);
        set_v[d][1:0] = b;
        step(4);
        set_v[d][1:0] = 2'b00;
        step(4);
    endtask

    task automatic cmp7(input string nm, input string fld, input logic [6:0] a, input logic [6:0] x);
        n_chk++;
        if (a !== x) begin
            n_err++;
            $display("FAIL %s.%s: got %b want %b", nm, fld, a, x);
        end
    endtask

    task automatic cmp1(input string nm, input string fld, input logic a, input logic x);
        n_chk++;
        if (a !== x) begin
            n_err++;
            $display("FAIL %s.%s: got %b want %b", nm, fld, a, x);
        end
    endtask

    // Monitor: compares everything queued whenever the stimulus strobes a sample.
    always @(negedge clk) begin
        if (smp) begin
            while (exp_q.size() > 0) begin
                cur = exp_q.pop_front();
                cmp1(cur.name, "tick", tick_o[cur.dut], cur.tick);
                if (cur.disp) begin
                    cmp7(cur.name, "D_H1", h1[cur.dut], cur.h1);
                    cmp7(cur.name, "D_H2", h2[cur.dut], cur.h2);
                    cmp7(cur.name, "D_M1", m1[cur.dut], cur.m1);
                    cmp7(cur.name, "D_M2", m2[cur.dut], cur.m2);
                    cmp7(cur.name, "D_S1", s1[cur.dut], cur.s1);
                    cmp7(cur.name, "D_S2", s2[cur.dut], cur.s2);
                    cmp1(cur.name, "pm", pm_o[cur.dut], cur.pm);
                end
            end
        end
    end

    initial begin
        for (int i = 0; i < 3; i++) begin
            rst_n[i] = 1'b0;
            set_v[i] = 4'b0000;
        end
        step(3);
        push_exp(0, "rst24", 0, 0, 0, 0, 0, 0, 1'b0, 1'b0, 1'b0);
        push_exp(1, "rst12", 1, 2, 0, 0, 0, 0, 1'b0, 1'b0, 1'b0);
        push_exp(2, "rst_al", 0, 0, 0, 0, -1, -1, 1'b0, 1'b0, 1'b1);
        do_sample();

        // ---- 24h build: free-running ticks ----
        rst_n[0] = 1'b1;
        for (int k = 1; k <= 100; k++) begin
            step(1);
            push_tick(0, "tick_seq", (k % 10) == 0);
            do_sample();
        end
        step(1);
        push_exp(0, "sec10", 0, 0, 0, 0, 1, 0, 1'b0, 1'b0, 1'b0);
        do_sample();

        // Set mode with decrement: seconds clear, minute 00->59, hour 00->23.
        set_v[0] = 4'b1100;
        step(4);
        push_exp(0, "set_clr", 0, 0, 0, 0, 0, 0, 1'b0, 1'b0, 1'b0);
        do_sample();
        pulse(0, 2'b01);
        push_exp(0, "min_dec", 0, 0, 5, 9, 0, 0, 1'b0, 1'b0, 1'b0);
        do_sample();
        pulse(0, 2'b10);
        push_exp(0, "hr_dec", 2, 3, 5, 9, 0, 0, 1'b0, 1'b0, 1'b0);
        do_sample();
        set_v[0][2] = 1'b0;
        step(4);
        pulse(0, 2'b11);
        push_exp(0, "both_inc", 0, 0, 0, 0, 0, 0, 1'b0, 1'b0, 1'b0);
        do_sample();
        set_v[0][2] = 1'b1;
        step(4);
        pulse(0, 2'b11);
        push_exp(0, "both_dec", 2, 3, 5, 9, 0, 0, 1'b0, 1'b0, 1'b0);
        do_sample();

        // Leave set mode while pulsing both steps: steps must be ignored.
        set_v[0] = 4'b0011;
        step(4);
        set_v[0] = 4'b0000;
        step(4);
        push_exp(0, "ignored", 2, 3, 5, 9, 0, 0, 1'b0, 1'b0, 1'b0);
        do_sample();
        step(585);
        push_exp(0, "t59", 2, 3, 5, 9, 5, 9, 1'b0, 1'b0, 1'b0);
        do_sample();
        step(9);
        push_exp(0, "tick60", 2, 3, 5, 9, 5, 9, 1'b0, 1'b1, 1'b0);
        do_sample();
        step(1);
        push_exp(0, "day_wrap", 0, 0, 0, 0, 0, 0, 1'b0, 1'b0, 1'b0);
        do_sample();

        // ---- 12h build ----
        rst_n[1] = 1'b1;
        set_v[1] = 4'b1000;
        step(4);
        push_exp(1, "set12", 1, 2, 0, 0, 0, 0, 1'b0, 1'b0, 1'b0);
        do_sample();
        pulse(1, 2'b10);
        push_exp(1, "h12_to_1", -1, 1, 0, 0, 0, 0, 1'b0, 1'b0, 1'b0);
        do_sample();
        for (int i = 0; i < 10; i++) pulse(1, 2'b10);
        set_v[1][2] = 1'b1;
        step(4);
        pulse(1, 2'b01);
        push_exp(1, "at1159", 1, 1, 5, 9, 0, 0, 1'b0, 1'b0, 1'b0);
        do_sample();
        set_v[1][2] = 1'b0;
        step(4);
        pulse(1, 2'b10);
        push_exp(1, "step_pm", 1, 2, 5, 9, 0, 0, 1'b1, 1'b0, 1'b0);
        do_sample();
        set_v[1][2] = 1'b1;
        step(4);
        pulse(1, 2'b10);
        push_exp(1, "step_am", 1, 1, 5, 9, 0, 0, 1'b0, 1'b0, 1'b0);
        do_sample();
        set_v[1] = 4'b0000;
        step(603);
        push_exp(1, "noon", 1, 2, 0, 0, 0, 0, 1'b1, 1'b0, 1'b0);
        do_sample();
        step(36000);
        push_exp(1, "one_pm", -1, 1, 0, 0, 0, 0, 1'b1, 1'b0, 1'b0);
        do_sample();

        // ---- active-low build: set 12:34, run to :56, reset on a tick edge ----
        rst_n[2] = 1'b1;
        set_v[2] = 4'b1000;
        step(4);
        for (int i = 0; i < 12; i++) pulse(2, 2'b11);
        for (int i = 0; i < 22; i++) pulse(2, 2'b01);
        push_exp(2, "al_set", 1, 2, 3, 4, -1, -1, 1'b0, 1'b0, 1'b1);
        do_sample();
        set_v[2] = 4'b0000;
        step(566);
        push_exp(2, "al_run", 1, 2, 3, 4, -1, -1, 1'b0, 1'b0, 1'b1);
        do_sample();
        step(5);
        rst_n[2] = 1'b0;
        step(1);
        push_exp(2, "al_rst", 0, 0, 0, 0, -1, -1, 1'b0, 1'b0, 1'b1);
        do_sample();
        n_chk++;
        if (m2[2] !== 7'b0000001) begin
            n_err++;
            $display("FAIL al_rst.D_M2_lit: got %b want %b", m2[2], 7'b0000001);
        end
        rst_n[2] = 1'b1;
        step(10);
        push_tick(2, "al_tick", 1'b1);
        do_sample();

        step(2);
        n_chk++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL queue_drain: got %0d left want 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
